// File: rtl/prefetch_fill_resp_pkg.sv
// Shared constants and FSM state encoding for the D-side prefetch fill responder.
package prefetch_fill_resp_pkg;

  localparam int PFR_PABITS   = 32;
  localparam int PFR_LINE_LEN = 5;
  localparam int PFR_FILT_NUM = 4;
  localparam int PFR_CNT_W    = 16;

  typedef enum logic [2:0] {
    PFR_IDLE   = 3'd0,
    PFR_LOOKUP = 3'd1,
    PFR_CHECK  = 3'd2,
    PFR_REQ    = 3'd3,
    PFR_WAIT   = 3'd4
  } pfr_state_e;

endpackage

// File: rtl/prefetch_fill_resp_filter.sv
// Recent-line filter: small CAM of line tags with round-robin replacement and flush.
module prefetch_line_filter
  import prefetch_fill_resp_pkg::*;
#(
  parameter int TAG_W    = PFR_PABITS - PFR_LINE_LEN,
  parameter int FILT_NUM = PFR_FILT_NUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [TAG_W-1:0] lkup_tag,
  output logic             hit,
  input  logic             ins,
  input  logic [TAG_W-1:0] ins_tag
);

  localparam int PTR_W = (FILT_NUM > 1) ? $clog2(FILT_NUM) : 1;

  logic [FILT_NUM-1:0] vld;
  logic [TAG_W-1:0]    tags [FILT_NUM];
  logic [PTR_W-1:0]    ptr;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FILT_NUM; i++) begin
      if (vld[i] && (tags[i] == lkup_tag)) hit = 1'b1;
    end
  end

  // Flush wins over a same-cycle insert; the insert is lost and the pointer holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      ptr <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (ins) begin
      vld[ptr] <= 1'b1;
      ptr      <= (ptr == PTR_W'(FILT_NUM - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && ins) tags[ptr] <= ins_tag;
  end

endmodule

// File: rtl/prefetch_fill_resp.sv
// Prefetch request responder: filters redundant lines, issues one line read, streams beats to fill.
//   state  | meaning
//   IDLE   | waiting for a prefetch head; pops it and checks the recent-line filter
//   LOOKUP | probing dcache tags for the latched line
//   CHECK  | sampling probe result; holds a miss while demand owns the refill port
//   REQ    | line read request held until accepted
//   WAIT   | receiving return beats into the fill path
module prefetch_fill_resp
  import prefetch_fill_resp_pkg::*;
#(
  parameter int PABITS   = PFR_PABITS,
  parameter int LINE_LEN = PFR_LINE_LEN,
  parameter int FILT_NUM = PFR_FILT_NUM,
  parameter int CNT_W    = PFR_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pf_req,
  input  logic [1:0]          pf_pgcl,
  input  logic [PABITS-1:0]   pf_paddr,
  output logic                pf_recv,
  input  logic                demand_busy,
  input  logic                filt_flush,
  output logic                lkup_valid,
  output logic [PABITS-1:0]   lkup_paddr,
  input  logic                lkup_hit,
  output logic                mem_rd_req,
  output logic [PABITS-1:0]   mem_rd_addr,
  output logic [1:0]          mem_rd_pgcl,
  input  logic                mem_rd_addr_ok,
  input  logic                mem_ret_valid,
  input  logic                mem_ret_last,
  input  logic [31:0]         mem_ret_data,
  output logic                fill_wen,
  output logic [PABITS-1:0]   fill_paddr,
  output logic [LINE_LEN-3:0] fill_beat,
  output logic [31:0]         fill_data,
  output logic                fill_done,
  output logic                busy,
  output logic [CNT_W-1:0]    issue_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam int TAG_W = PABITS - LINE_LEN;

  pfr_state_e          state, state_nxt;
  logic [PABITS-1:0]   addr_q;
  logic [1:0]          pgcl_q;
  logic                recv_q;
  logic                chk_held;
  logic [LINE_LEN-3:0] beat_q;
  logic [CNT_W-1:0]    issue_cnt_q, drop_cnt_q;
  logic                accept, filt_hit, beat_fire, drop_inc, issue_inc;

  // recv_q blocks back-to-back pops: the prefetcher head only advances a cycle later.
  assign accept    = !rst && (state == PFR_IDLE) && pf_req && !demand_busy && !recv_q;
  assign beat_fire = (state == PFR_WAIT) && mem_ret_valid;

  prefetch_line_filter #(
    .TAG_W    (TAG_W),
    .FILT_NUM (FILT_NUM)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .flush    (filt_flush),
    .lkup_tag (pf_paddr[PABITS-1:LINE_LEN]),
    .hit      (filt_hit),
    .ins      (accept && !filt_hit),
    .ins_tag  (pf_paddr[PABITS-1:LINE_LEN])
  );

  always_comb begin
    state_nxt = state;
    drop_inc  = 1'b0;
    issue_inc = 1'b0;
    case (state)
      PFR_IDLE: begin
        if (accept) begin
          if (filt_hit) drop_inc  = 1'b1;
          else          state_nxt = PFR_LOOKUP;
        end
      end
      PFR_LOOKUP: state_nxt = PFR_CHECK;
      PFR_CHECK: begin
        // lkup_hit is only meaningful on the first CHECK cycle; later cycles hold a miss.
        if (!chk_held && lkup_hit) begin
          drop_inc  = 1'b1;
          state_nxt = PFR_IDLE;
        end else if (!demand_busy) begin
          state_nxt = PFR_REQ;
        end
      end
      PFR_REQ: begin
        if (mem_rd_addr_ok) begin
          issue_inc = 1'b1;
          state_nxt = PFR_WAIT;
        end
      end
      PFR_WAIT: begin
        if (mem_ret_valid && mem_ret_last) state_nxt = PFR_IDLE;
      end
      default: state_nxt = PFR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PFR_IDLE;
      addr_q      <= '0;
      pgcl_q      <= '0;
      recv_q      <= 1'b0;
      chk_held    <= 1'b0;
      beat_q      <= '0;
      issue_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state    <= state_nxt;
      recv_q   <= accept;
      chk_held <= (state == PFR_CHECK) && (state_nxt == PFR_CHECK);
      if (accept) begin
        addr_q <= pf_paddr;
        pgcl_q <= pf_pgcl;
      end
      if (issue_inc)      beat_q <= '0;
      else if (beat_fire) beat_q <= beat_q + 1'b1;
      if (issue_inc) issue_cnt_q <= issue_cnt_q + 1'b1;
      if (drop_inc)  drop_cnt_q  <= drop_cnt_q + 1'b1;
    end
  end

  assign pf_recv     = accept;
  assign lkup_valid  = (state == PFR_LOOKUP);
  assign lkup_paddr  = lkup_valid ? addr_q : '0;
  assign mem_rd_req  = (state == PFR_REQ);
  assign mem_rd_addr = mem_rd_req ? addr_q : '0;
  assign mem_rd_pgcl = mem_rd_req ? pgcl_q : '0;
  assign fill_wen    = beat_fire;
  assign fill_paddr  = beat_fire ? addr_q : '0;
  assign fill_beat   = beat_fire ? beat_q : '0;
  assign fill_data   = beat_fire ? mem_ret_data : '0;
  assign fill_done   = beat_fire && mem_ret_last;
  assign busy        = (state != PFR_IDLE);
  assign issue_cnt   = issue_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_prefetch_fill_resp.sv
// Self-checking bench for prefetch_fill_resp: request table plus hand-written corner sequences.
module tb_prefetch_fill_resp;

  logic        clk, rst;
  logic        pf_req;
  logic [1:0]  pf_pgcl;
  logic [31:0] pf_paddr;
  logic        pf_recv;
  logic        demand_busy, filt_flush;
  logic        lkup_valid;
  logic [31:0] lkup_paddr;
  logic        lkup_hit;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic [1:0]  mem_rd_pgcl;
  logic        mem_rd_addr_ok, mem_ret_valid, mem_ret_last;
  logic [31:0] mem_ret_data;
  logic        fill_wen;
  logic [31:0] fill_paddr;
  logic [2:0]  fill_beat;
  logic [31:0] fill_data;
  logic        fill_done, busy;
  logic [15:0] issue_cnt, drop_cnt;
  logic [255:0] all_out;

  prefetch_fill_resp dut (
    .clk(clk), .rst(rst), .pf_req(pf_req), .pf_pgcl(pf_pgcl), .pf_paddr(pf_paddr),
    .pf_recv(pf_recv), .demand_busy(demand_busy), .filt_flush(filt_flush),
    .lkup_valid(lkup_valid), .lkup_paddr(lkup_paddr), .lkup_hit(lkup_hit),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_pgcl(mem_rd_pgcl),
    .mem_rd_addr_ok(mem_rd_addr_ok), .mem_ret_valid(mem_ret_valid),
    .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data), .fill_wen(fill_wen),
    .fill_paddr(fill_paddr), .fill_beat(fill_beat), .fill_data(fill_data),
    .fill_done(fill_done), .busy(busy), .issue_cnt(issue_cnt), .drop_cnt(drop_cnt)
  );

  assign all_out = 256'({pf_recv, lkup_valid, lkup_paddr, mem_rd_req, mem_rd_addr, mem_rd_pgcl,
                         fill_wen, fill_paddr, fill_beat, fill_data, fill_done, busy,
                         issue_cnt, drop_cnt});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] paddr;
    logic [1:0]  pgcl;
    bit          lhit;
    bit          flush;
    bit          exp_fhit;
    int          nbeats;
  } vec_t;

  typedef struct {
    logic [2:0]  beat;
    logic [31:0] data;
    logic        done;
    logic [31:0] paddr;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_issue = 0;
  int    exp_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beats(input logic [31:0] addr, input int n, input bit end_line);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      mem_ret_valid = 1'b1;
      mem_ret_data  = $urandom;
      mem_ret_last  = end_line && (i == n - 1);
      b.beat  = 3'(i);
      b.data  = mem_ret_data;
      b.done  = mem_ret_last;
      b.paddr = addr;
      exp_q.push_back(b);
      cyc();
    end
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
  endtask

  task automatic do_request(input vec_t v, input bit abort);
    cyc();
    if (v.flush) begin
      filt_flush = 1'b1;
      cyc();
      filt_flush = 1'b0;
    end
    pf_req = 1'b1; pf_paddr = v.paddr; pf_pgcl = v.pgcl;
    #1;
    check("pf_recv", pf_recv, 1);
    cyc();
    check("pf_recv_gap", pf_recv, 0);
    pf_req = 1'b0;
    #1;
    if (v.exp_fhit) begin
      exp_drop++;
      check("filt_no_lkup", lkup_valid, 0);
      check("filt_drop_cnt", drop_cnt, 64'(exp_drop));
      return;
    end
    check("lkup_valid", lkup_valid, 1);
    check("lkup_paddr", lkup_paddr, v.paddr);
    cyc();
    lkup_hit = v.lhit;
    #1;
    check("check_no_req", mem_rd_req, 0);
    cyc();
    lkup_hit = 1'b0;
    #1;
    if (v.lhit) begin
      exp_drop++;
      check("hit_idle", busy, 0);
      check("hit_no_req", mem_rd_req, 0);
      check("hit_drop_cnt", drop_cnt, 64'(exp_drop));
      return;
    end
    check("mem_rd_req", mem_rd_req, 1);
    check("mem_rd_addr", {mem_rd_pgcl, mem_rd_addr}, {v.pgcl, v.paddr});
    mem_rd_addr_ok = 1'b1;
    cyc();
    mem_rd_addr_ok = 1'b0;
    exp_issue++;
    #1;
    check("req_cleared", mem_rd_req, 0);
    check("issue_cnt", issue_cnt, 64'(exp_issue));
    run_beats(v.paddr, v.nbeats, !abort);
    if (!abort) begin
      #1;
      check("fill_idle", busy, 0);
    end
  endtask

  // Scoreboard consumer: every fill beat must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (fill_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("fill_unexpected", fill_wen, 0);
      end else begin
        e = exp_q.pop_front();
        check("fill_beat", fill_beat, e.beat);
        check("fill_data", fill_data, e.data);
        check("fill_done", fill_done, e.done);
        check("fill_paddr", fill_paddr, e.paddr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;

    rst = 1'b1; pf_req = 1'b0; pf_pgcl = '0; pf_paddr = '0; demand_busy = 1'b0;
    filt_flush = 1'b0; lkup_hit = 1'b0; mem_rd_addr_ok = 1'b0; mem_ret_valid = 1'b0;
    mem_ret_last = 1'b0; mem_ret_data = '0;

    //          paddr          pgcl  lhit  flush fhit  beats
    tbl[0]  = '{32'h0000_1240, 2'd1, 1'b0, 1'b0, 1'b0, 8};
    tbl[1]  = '{32'h0000_1240, 2'd1, 1'b0, 1'b0, 1'b1, 0};
    tbl[2]  = '{32'h0000_2000, 2'd2, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{32'h0000_4000, 2'd0, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{32'h0000_5000, 2'd0, 1'b1, 1'b0, 1'b0, 0};
    tbl[5]  = '{32'h0000_6000, 2'd0, 1'b1, 1'b0, 1'b0, 0};
    tbl[6]  = '{32'h0000_7000, 2'd0, 1'b1, 1'b0, 1'b0, 0};
    tbl[7]  = '{32'h0000_8000, 2'd0, 1'b1, 1'b0, 1'b0, 0};
    tbl[8]  = '{32'h0000_4000, 2'd0, 1'b1, 1'b0, 1'b0, 0};
    tbl[9]  = '{32'h0000_8000, 2'd0, 1'b0, 1'b0, 1'b1, 0};
    tbl[10] = '{32'h0000_5000, 2'd3, 1'b0, 1'b0, 1'b0, 8};
    tbl[11] = '{32'h0000_8000, 2'd0, 1'b1, 1'b1, 1'b0, 0};

    cyc(); cyc();
    check("reset_outs", 64'(|all_out), 0);
    rst = 1'b0;
    cyc();
    check("post_reset_outs", 64'(|all_out), 0);

    for (int i = 0; i < 12; i++) do_request(tbl[i], 1'b0);

    // demand_busy blocks IDLE and CHECK, but not REQ or WAIT
    cyc();
    demand_busy = 1'b1; pf_req = 1'b1; pf_paddr = 32'h0000_3000; pf_pgcl = 2'd3;
    #1;
    check("busy_no_recv", pf_recv, 0);
    cyc();
    check("busy_no_recv2", pf_recv, 0);
    check("busy_still_idle", busy, 0);
    demand_busy = 1'b0;
    #1;
    check("busy_fall_recv", pf_recv, 1);
    cyc();
    pf_req = 1'b0; demand_busy = 1'b1;
    #1;
    check("busy_lkup", lkup_valid, 1);
    cyc();
    lkup_hit = 1'b0;
    #1;
    check("busy_check_no_req", mem_rd_req, 0);
    cyc();
    lkup_hit = 1'b1;
    #1;
    check("busy_check_held", busy, 1);
    check("busy_check_no_req2", mem_rd_req, 0);
    cyc();
    lkup_hit = 1'b0; demand_busy = 1'b0;
    #1;
    check("busy_check_no_req3", mem_rd_req, 0);
    cyc();
    demand_busy = 1'b1;
    #1;
    check("busy_req", mem_rd_req, 1);
    check("busy_no_drop", drop_cnt, 64'(exp_drop));
    cyc();
    check("req_held", mem_rd_req, 1);
    check("req_held_addr", {mem_rd_pgcl, mem_rd_addr}, {2'd3, 32'h0000_3000});
    mem_rd_addr_ok = 1'b1;
    cyc();
    mem_rd_addr_ok = 1'b0;
    exp_issue++;
    #1;
    check("busy_issue_cnt", issue_cnt, 64'(exp_issue));
    run_beats(32'h0000_3000, 8, 1'b1);
    #1;
    check("busy_fill_idle", busy, 0);
    demand_busy = 1'b0;

    // last beat ends the line early; next line restarts at beat 0
    v = '{32'h0000_9000, 2'd1, 1'b0, 1'b0, 1'b0, 3};
    do_request(v, 1'b0);
    v = '{32'h0000_C000, 2'd2, 1'b0, 1'b0, 1'b0, 8};
    do_request(v, 1'b0);

    // flush in the same cycle as an insert: the insert is lost
    cyc();
    pf_req = 1'b1; pf_paddr = 32'h0000_A000; pf_pgcl = 2'd0; filt_flush = 1'b1;
    #1;
    check("flush_ins_recv", pf_recv, 1);
    cyc();
    pf_req = 1'b0; filt_flush = 1'b0;
    #1;
    check("flush_ins_lkup", lkup_valid, 1);
    cyc();
    lkup_hit = 1'b1;
    cyc();
    lkup_hit = 1'b0;
    exp_drop++;
    #1;
    check("flush_ins_drop", drop_cnt, 64'(exp_drop));
    v = '{32'h0000_A000, 2'd0, 1'b1, 1'b0, 1'b0, 0};
    do_request(v, 1'b0);
    v = '{32'h0000_9000, 2'd0, 1'b1, 1'b0, 1'b0, 0};
    do_request(v, 1'b0);

    // reset mid-line after beat 3
    v = '{32'h0000_B000, 2'd2, 1'b0, 1'b0, 1'b0, 4};
    do_request(v, 1'b1);
    check("abort_in_wait", busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_ret_valid = 1'b1; mem_ret_data = 32'hDEAD_BEEF;
    #1;
    check("rst_outs", 64'(|all_out), 0);
    for (int i = 5; i < 8; i++) begin
      cyc();
      mem_ret_data = $urandom;
      mem_ret_last = (i == 7);
      #1;
      check("rst_no_fill", fill_wen, 0);
      check("rst_idle", busy, 0);
    end
    cyc();
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    cyc();
    check("beats_outstanding", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
